// File: rtl/bscac_fifo_read_sched.sv
// bscac_fifo_read_sched: crosstalk-aware per-lane FIFO pop scheduler and encoder state register for BSCAC-N
module bscac_fifo_read_sched #(
  parameter int N = 7,
  parameter logic [N-1:0] INIT_STATE = '0,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bypass,
  input  logic [N-1:0]         fifo_empty,
  input  logic [N-1:0]         fifo_dout,
  output logic [N-1:0]         fifo_rd_en,
  output logic [N-1:0]         out_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*CNT_W-1:0]   lock_cnt
);
  logic [N-1:0] cur, d, nxt;
  logic [N-1:1] pv, free;
  logic step;
  assign step = rst_n & ~fifo_empty[0] & (~out_valid | out_ready);
  assign d = (fifo_empty & cur) | (~fifo_empty & fifo_dout);
  assign pv = ~(cur[N-1:1] ^ {(N-1){cur[0]}});
  assign fifo_rd_en = step ? {free & ~fifo_empty[N-1:1], 1'b1} : '0;
  always_comb begin
    int p, s;
    logic up, us, u1;
    p = 1;
    s = 1;
    up = 1'b0;
    us = 1'b0;
    u1 = 1'b0;
    free = '0;
    nxt = cur;
    nxt[0] = d[0];
    for (int i = 1; i < N; i++) begin
      p = (i == 1) ? N - 1 : i - 1;
      s = (i == N - 1) ? 1 : i + 1;
      up = cur[p] == ((p < i) ? nxt[p] : d[p]);
      us = cur[s] == ((s < i) ? nxt[s] : d[s]);
      u1 = cur[1] == nxt[1];
      free[i] = bypass | ((d[0] == cur[0])
        ? (i == 1) | (cur[i] == cur[i-1]) | up
        : pv[i] | (~pv[p] & ~pv[s]) | ((i != 1) & ~pv[p] & ~up) | (pv[p] & pv[s] & up & us)
          | ((i == N - 1) & ~pv[1] & ~u1));
      nxt[i] = free[i] ? d[i] : cur[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur <= INIT_STATE;
      out_word <= '0;
      out_valid <= 1'b0;
      lock_cnt <= '0;
    end else if (step) begin
      cur <= nxt;
      out_word <= nxt;
      out_valid <= 1'b1;
      for (int i = 1; i < N; i++)
        if (!free[i] && !fifo_empty[i] && !(&lock_cnt[i*CNT_W +: CNT_W]))
          lock_cnt[i*CNT_W +: CNT_W] <= lock_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
